sqrt_arg_issue: RTL and testbench

Upstream feeder for the multi-cycle square-root stage, which has no backpressure and must not receive a new argument while a computation is in flight. The block accepts arguments on a valid/ready stream and buffers them in a small FIFO. It issues them as single-cycle arg_vld pulses spaced at least ISSUE_GAP cycles apart. Its out_vld/out_data outputs connect directly to the sqrt stage's arg_vld/arg.

---
 rtl/sqrt_arg_issue.sv | 118 +++++++++++
 tb/tb_sqrt_arg_issue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arg_issue.sv
// Argument feeder for the multi-cycle sqrt stage: buffers a valid/ready stream in a
// small FIFO and issues one-cycle arg pulses no closer than ISSUE_GAP cycles apart.
module sqrt_arg_issue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ISSUE_GAP  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_vld,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(ISSUE_GAP + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [GW-1:0]         gap_cnt_reg, gap_cnt_next;
    logic                  out_vld_reg, out_vld_next;
    logic [DATA_WIDTH-1:0] out_data_reg;
    state_t                state;
    logic                  push;
    logic                  issue;

    assign in_rdy = (count_reg != FULL_COUNT);
    assign push   = in_vld && in_rdy;

    // The gap counter and occupancy together are the state; this just decodes them.
    always_comb begin
        state = IDLE;
        if (gap_cnt_reg != '0) begin
            state = WAIT;
        end else if (count_reg != '0) begin
            state = ISSUE;
        end
    end

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        gap_cnt_next = gap_cnt_reg;
        out_vld_next = 1'b0;
        issue        = 1'b0;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end

        unique case (state)
            ISSUE: begin
                issue        = 1'b1;
                out_vld_next = 1'b1;
                rd_ptr_next  = rd_ptr_reg + AW'(1);
                gap_cnt_next = GAP_RELOAD;
            end
            WAIT: begin
                gap_cnt_next = gap_cnt_reg - GW'(1);
            end
            default: begin
            end
        endcase

        count_next = count_reg + CW'(push) - CW'(issue);
    end

    // Storage is left unreset; a flushed push must not land in it either.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            gap_cnt_reg  <= '0;
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            gap_cnt_reg  <= '0;
            out_vld_reg  <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            gap_cnt_reg  <= gap_cnt_next;
            out_vld_reg  <= out_vld_next;
            if (issue) begin
                out_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign out_vld  = out_vld_reg;
    assign out_data = out_data_reg;
    assign count    = count_reg;
    assign busy     = (count_reg != '0) || out_vld_reg || (gap_cnt_reg != '0);

endmodule

// File: tb/tb_sqrt_arg_issue.sv
// Bench for sqrt_arg_issue: a scoreboard holds (data, expected issue edge) pairs that the
// pulse monitor pops and compares; scenario tasks check levels and handshakes inline.
module tb_sqrt_arg_issue;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_data = '0;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          busy;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sqrt_arg_issue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_data(in_data), .out_vld(out_vld), .out_data(out_data), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic rec_t mk(input logic [DW-1:0] d, input int e);
        rec_t r;
        r.d = d;
        r.e = e;
        return r;
    endfunction

    // Pulse monitor: each issued word must be the oldest expected one, on its predicted edge.
    always @(negedge clk) begin
        if (out_vld) begin
            $display("pulse edge %0d data %02h count %0d", edge_cnt, out_data, count);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got data %02h at edge %0d, required no pulse", out_data, edge_cnt);
            end else begin
                mon_r = exp_q.pop_front();
                n_cmp++;
                if (out_data !== mon_r.d) begin
                    n_err++;
                    $display("FAIL pulse_data: got %02h required %02h (edge %0d)", out_data, mon_r.d, edge_cnt);
                end
                n_cmp++;
                if (edge_cnt != mon_r.e) begin
                    n_err++;
                    $display("FAIL pulse_edge: data %02h got edge %0d required edge %0d", mon_r.d, edge_cnt, mon_r.e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_vld = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld: got %b required 0", out_vld); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %02h required 00", out_data); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", count); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_single();
        int t;
        bit to;
        t = edge_cnt + 1;
        in_vld = 1'b1;
        in_data = 8'h51;
        exp_q.push_back(mk(8'h51, t + 1));
        step();
        in_vld = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_after_push: got %0d required 1", count); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_no_same_cycle_issue: got %b required 0", out_vld); end
        step();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_after_issue: got %0d required 0", count); end
        n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL single_out_vld: got %b required 1", out_vld); end
        step();
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b required 0", out_vld); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_gap: got %b required 1", busy); end
        repeat (3) step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_last_gap: got %b required 1", busy); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b required 0", busy); end
        n_cmp++; if (out_data !== 8'h51) begin n_err++; $display("FAIL single_out_data_hold: got %02h required 51", out_data); end
        wait_idle(to);
        n_cmp++; if (to || exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: timeout %0d pending %0d required 0/0", to, exp_q.size()); end
    endtask

    task automatic test_burst();
        int t0;
        bit to;
        logic [DW-1:0] v;
        t0 = edge_cnt + 1;
        for (int k = 0; k < 4; k++) begin
            v = DW'(8'h10 * (k + 1));
            in_vld = 1'b1;
            in_data = v;
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL burst_in_rdy[%0d]: got %b required 1", k, in_rdy); end
            exp_q.push_back(mk(v, t0 + 1 + GAP * k));
            step();
        end
        in_vld = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL burst_count: got %0d required 3", count); end
        wait_idle(to);
        n_cmp++; if (to || exp_q.size() != 0) begin n_err++; $display("FAIL burst_drain: timeout %0d pending %0d required 0/0", to, exp_q.size()); end
    endtask

    task automatic test_full();
        int t0;
        int w;
        bit rdy_e;
        bit to;
        t0 = edge_cnt + 1;
        w = 0;
        for (int i = 0; i < 20 && w < 6; i++) begin
            in_vld = 1'b1;
            in_data = DW'(8'hA0 + w);
            rdy_e = !(i >= 5 && i <= 7);
            n_cmp++; if (in_rdy !== rdy_e) begin n_err++; $display("FAIL full_in_rdy[%0d]: got %b required %b", i, in_rdy, rdy_e); end
            if (i == 5) begin
                n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d required 4", count); end
            end
            if (rdy_e) begin
                exp_q.push_back(mk(DW'(8'hA0 + w), t0 + 1 + GAP * w));
                w++;
            end
            step();
        end
        in_vld = 1'b0;
        wait_idle(to);
        n_cmp++; if (to || exp_q.size() != 0) begin n_err++; $display("FAIL full_drain: timeout %0d pending %0d required 0/0", to, exp_q.size()); end
    endtask

    task automatic test_wrap();
        int pe[10] = '{0, 2, 3, 7, 13, 19, 25, 31, 37, 43};
        int t0;
        int w;
        bit sim;
        bit to;
        t0 = edge_cnt + 1;
        w = 0;
        for (int i = 0; i <= 43; i++) begin
            sim = 1'b0;
            in_vld = 1'b0;
            if (w < 10 && pe[w] == i) begin
                in_vld = 1'b1;
                in_data = DW'(8'hC0 + w);
                exp_q.push_back(mk(DW'(8'hC0 + w), t0 + 1 + GAP * w));
                sim = (i >= 7);
                w++;
            end
            step();
            if (sim) begin
                n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL wrap_count@%0d: got %0d required 2", i, count); end
                n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL wrap_issue@%0d: got %b required 1", i, out_vld); end
            end
        end
        in_vld = 1'b0;
        wait_idle(to);
        n_cmp++; if (to || exp_q.size() != 0) begin n_err++; $display("FAIL wrap_drain: timeout %0d pending %0d required 0/0", to, exp_q.size()); end
    endtask

    task automatic test_flush();
        int t0;
        bit to;
        t0 = edge_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1;
            in_data = DW'(8'h31 + i);
            if (i == 0) exp_q.push_back(mk(8'h31, t0 + 1));
            step();
        end
        n_cmp++; if (count !== 3'd3 || busy !== 1'b1) begin n_err++; $display("FAIL flush_setup: got count %0d busy %b required 3/1", count, busy); end
        flush = 1'b1;
        in_vld = 1'b1;
        in_data = 8'hEE;
        step();
        flush = 1'b0;
        in_vld = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d required 0", count); end
        n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL flush_out_vld: got %b required 0", out_vld); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b required 0", busy); end
        n_cmp++; if (out_data !== 8'h31) begin n_err++; $display("FAIL flush_out_data_hold: got %02h required 31", out_data); end
        in_vld = 1'b1;
        in_data = 8'h77;
        exp_q.push_back(mk(8'h77, edge_cnt + 2));
        step();
        in_vld = 1'b0;
        step();
        n_cmp++; if (out_vld !== 1'b1 || out_data !== 8'h77) begin n_err++; $display("FAIL flush_next_issue: got vld %b data %02h required 1/77", out_vld, out_data); end
        wait_idle(to);
        n_cmp++; if (to || exp_q.size() != 0) begin n_err++; $display("FAIL flush_drain: timeout %0d pending %0d required 0/0", to, exp_q.size()); end
    endtask

    task automatic test_midstream_reset();
        int t0;
        bit to;
        logic [DW-1:0] v;
        for (int f = 0; f < 2; f++) begin
            t0 = edge_cnt + 1;
            for (int i = 0; i < 3; i++) begin
                in_vld = 1'b1;
                in_data = DW'(8'h61 + i);
                if (i == 0) exp_q.push_back(mk(8'h61, t0 + 1));
                step();
            end
            rst = 1'b1;
            flush = f[0];
            in_vld = 1'b1;
            in_data = 8'h99;
            step();
            rst = 1'b0;
            flush = 1'b0;
            in_vld = 1'b0;
            n_cmp++; if (out_vld !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL rst%0d_out: got vld %b data %02h required 0/00", f, out_vld, out_data); end
            n_cmp++; if (count !== 3'd0 || in_rdy !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst%0d_state: got count %0d rdy %b busy %b required 0/1/0", f, count, in_rdy, busy); end
            t0 = edge_cnt + 1;
            for (int k = 0; k < 4; k++) begin
                v = DW'(8'h80 + 16 * f + k);
                in_vld = 1'b1;
                in_data = v;
                exp_q.push_back(mk(v, t0 + 1 + GAP * k));
                step();
            end
            in_vld = 1'b0;
            wait_idle(to);
            n_cmp++; if (to || exp_q.size() != 0) begin n_err++; $display("FAIL rst%0d_drain: timeout %0d pending %0d required 0/0", f, to, exp_q.size()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_wrap();
        test_flush();
        test_midstream_reset();
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
